mul_sequencer: RTL
==================

# mul_sequencer

Multi-cycle shift-add multiply unit and its sequencing FSM for the 24-bit CPU. It services the `AluOp = 2'b11` (mul) class, which the single-cycle ALU cannot complete in one cycle. While decode presents a mul instruction, the block raises a combinational `Stall` that freezes the PC and register-file write enable. It drops `Stall` in the single cycle its registered product is valid for write-back.

## Interface
- `WIDTH`, default 24: operand and result width.
- `Clock`  in  1: rising-edge clock.
- `ResetN`  in  1: asynchronous, active-low reset.
- `AluOp`  in  2: from main control. `2'b11` is a mul request; any other value means no request.
- `Flush`  in  1: synchronous abort of any operation in progress.
- `OpA`  in  WIDTH: multiplicand (rs).
- `OpB`  in  WIDTH: multiplier (rt).
- `Stall`  out  1: combinational. Holds the CPU while a mul is pending.
- `Done`  out  1: registered. High for exactly one cycle when `Result` is fresh.
- `Busy`  out  1: registered. High while in RUN.
- `Result`  out  WIDTH: registered. Low WIDTH bits of the product.
- `ResultHi`  out  WIDTH: registered. High WIDTH bits of the product. Present only with `MUL_HIGH_EN`.

## Operation
- States are IDLE, RUN and DONE.
- The request is `MulReq = (AluOp == 2'b11)`.
- IDLE:
  - If `MulReq` is high: latch `OpA` and `OpB`, clear the accumulator, set `Count` = 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, once per cycle:
  - If multiplier bit 0 is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1.
  - Increment `Count`.
  - When `Count == WIDTH-1`, go to DONE and load `Result` (and `ResultHi`) from the final accumulator value.
- DONE:
  - `Done` = 1, then go to IDLE unconditionally.
  - `MulReq` in DONE is not a new request. The CPU advances on this edge, so the next instruction's request appears in IDLE.
- `Stall = MulReq && (state != DONE)`.
- Arithmetic:
  - Unsigned product.
  - `Result` is identical to the low WIDTH bits of a signed product.
  - The accumulator is 2·WIDTH bits with `MUL_HIGH_EN` and WIDTH bits without it.
  - Overflow beyond the accumulator is discarded silently.
- Operands are latched. Changes on `OpA`, `OpB` or `AluOp` during RUN are ignored.
- `Flush`:
  - Takes priority over every other transition: any state goes to IDLE and `Done` = 0.
  - `Result` and `ResultHi` keep their previous values.
- Reset (`ResetN` = 0), asynchronous, at any time including mid-RUN:
  - State = IDLE.
  - `Count`, accumulator and operand registers = 0.
  - `Result` = 0, `ResultHi` = 0, `Done` = 0, `Busy` = 0.
- `Stall` during reset: it is combinational, so it equals `MulReq`.

## Timing
- Request seen in IDLE at cycle 0. RUN occupies cycles 1..WIDTH. DONE is cycle WIDTH+1.
- Total is WIDTH+2 = 26 cycles at WIDTH = 24.
- `Stall` is high in cycles 0..WIDTH and low in cycle WIDTH+1.
- `Result` is valid from cycle WIDTH+1 and is held until the next completion or reset.
- Back-to-back muls: the second request enters IDLE at cycle WIDTH+2. There is no bubble beyond the DONE cycle.

## Configuration
- `MUL_HIGH_EN` defined:
  - 2·WIDTH accumulator and multiplicand.
  - `ResultHi` port present, carrying product bits [2·WIDTH-1:WIDTH].
- `MUL_HIGH_EN` undefined:
  - `ResultHi` port absent.
  - Accumulator and multiplicand are WIDTH bits.
  - `Result` and latency are unchanged.

## Structure
- Shared package `alu_pkg`:
  - AluOp encodings: `ALUOP_MEM` = 00, `ALUOP_BR` = 01, `ALUOP_R` = 10, `ALUOP_MUL` = 11.
  - ALU control codes (0000 and, 0001 or, 0010 add, 1010 sub, 0011 slt, 0100 mul, 0101 xor, 0110 sll).
  - The mul_sequencer state enum.
  - Default `WIDTH` = 24.
- One sub-module, `mul_datapath`: operand, shift and accumulator registers with a step/load/clear interface.
- The FSM, `Count`, `Stall` and `Done` live in `mul_sequencer`.

## Test plan
- `OpA` = 3, `OpB` = 5, `AluOp` = 11 held → `Stall` high for cycles 0..24, `Done` = 1 and `Result` = 15 in cycle 25.
- `OpA` = `OpB` = 0xFFFFFF → `Result` = 0x000001, `ResultHi` = 0xFFFFFE (with `MUL_HIGH_EN`).
- Operands changed to 7 × 7 in cycle 4 of a 3×5 op → `Result` = 15.
- `Flush` in cycle 10 after a prior `Result` = 15 → IDLE next cycle, no `Done`, `Result` stays 15.
- `ResetN` low in cycle 12 → immediate IDLE, `Result` = 0, `Busy` = 0. After release, a new 2×9 request → `Result` = 18.
- Two consecutive muls, 4×4 then 6×6 → `Done` pulses in cycles 25 and 51 with `Result` = 16 then 36. `AluOp` = 10 in IDLE → `Stall` = 0, state unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: AluOp classes, ALU control codes, mul sequencer
// states and the default datapath width.
package alu_pkg;

  localparam int MUL_WIDTH_DEF = 24;

  // Main-control AluOp classes
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_MUL = 2'b11;

  // ALU control codes
  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b1010;
  localparam logic [3:0] ALUCTL_SLT = 4'b0011;
  localparam logic [3:0] ALUCTL_MUL = 4'b0100;
  localparam logic [3:0] ALUCTL_XOR = 4'b0101;
  localparam logic [3:0] ALUCTL_SLL = 4'b0110;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_RUN  = 2'b01,
    MS_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiply datapath: multiplicand, multiplier and accumulator
// registers. load latches operands and clears the accumulator, step does one
// shift-add iteration, clear zeroes everything (abort). acc_nxt_o is the
// accumulator value after the current step, used to capture the final product.
module mul_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF,
  parameter int AW    = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [AW-1:0]    acc_nxt_o
);

  logic [AW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [AW-1:0]    acc_q;

  // Partial-product add for the current multiplier LSB; carries beyond AW drop
  always_comb begin
    acc_nxt_o = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Operand latch / shift-add iteration registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (clear_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= AW'(op_a_i);
      mplier_q <= op_b_i;
      acc_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_nxt_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle mul unit for the 24-bit CPU: IDLE -> RUN (WIDTH cycles) -> DONE.
// Stall holds the pipeline while a mul is decoded, dropping in the DONE cycle
// when Result is fresh. Optional macro MUL_HIGH_EN widens the accumulator to
// 2*WIDTH and adds the ResultHi port.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [1:0]       AluOp,
  input  logic             Flush,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Stall,
  output logic             Done,
  output logic             Busy,
`ifdef MUL_HIGH_EN
  output logic [WIDTH-1:0] ResultHi,
`endif
  output logic [WIDTH-1:0] Result
);

`ifdef MUL_HIGH_EN
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif
  localparam int          CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e       state_q;
  logic [CW-1:0]    count_q;
  logic             done_q;
  logic             busy_q;
  logic [WIDTH-1:0] result_q;
`ifdef MUL_HIGH_EN
  logic [WIDTH-1:0] result_hi_q;
`endif

  logic          mul_req;
  logic          dp_load;
  logic          dp_step;
  logic [AW-1:0] acc_nxt;

  // Request decode, stall and datapath controls; Flush overrides load/step
  always_comb begin
    mul_req = (AluOp == ALUOP_MUL);
    Stall   = mul_req && (state_q != MS_DONE);
    dp_load = !Flush && (state_q == MS_IDLE) && mul_req;
    dp_step = !Flush && (state_q == MS_RUN);
  end

  mul_datapath #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_dp (
    .clk_i     (Clock),
    .rst_ni    (ResetN),
    .clear_i   (Flush),
    .load_i    (dp_load),
    .step_i    (dp_step),
    .op_a_i    (OpA),
    .op_b_i    (OpB),
    .acc_nxt_o (acc_nxt)
  );

  // Sequencing FSM with registered Done/Busy/Result; Flush keeps old Result
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= MS_IDLE;
      count_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
`ifdef MUL_HIGH_EN
      result_hi_q <= '0;
`endif
    end else if (Flush) begin
      state_q <= MS_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          done_q <= 1'b0;
          if (mul_req) begin
            state_q <= MS_RUN;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        MS_RUN: begin
          count_q <= count_q + 1'b1;
          if (count_q == LAST) begin
            state_q     <= MS_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= acc_nxt[WIDTH-1:0];
`ifdef MUL_HIGH_EN
            result_hi_q <= acc_nxt[AW-1:WIDTH];
`endif
          end
        end
        MS_DONE: begin
          // Request seen here belongs to the finished instruction
          state_q <= MS_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= MS_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Done   = done_q;
  assign Busy   = busy_q;
  assign Result = result_q;
`ifdef MUL_HIGH_EN
  assign ResultHi = result_hi_q;
`endif

endmodule
